shared_tick_timer: RTL and testbench

- Single shared timebase (prescaler plus tick down-counter) time-shared among NREQ requesters.
- Each requester asks for a delay of N ticks (e.g. LED hold, key debounce window, RSA stage pacing).
- A round-robin arbiter grants the timer to one requester at a time and returns a one-cycle done pulse on expiry.
- Sits between the 10 MHz board clock domain and the top-level control FSMs; replaces per-FSM free-running dividers.

---
 rtl/shared_tick_timer_pkg.sv | 15 +
 rtl/rr_arbiter_comb.sv | 36 +++
 rtl/shared_tick_timer.sv | 142 ++++++++++++++
 tb/tb_shared_tick_timer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shared_tick_timer_pkg.sv
// Shared definitions for the time-shared tick timer: FSM encoding and
// the default tick divider derived from the 10 MHz board clock.
package shared_tick_timer_pkg;

   localparam int BOARD_CLK_HZ    = 10_000_000;
   localparam int TICK_MS         = 500;
   localparam int DEFAULT_CLK_DIV = BOARD_CLK_HZ / 1000 * TICK_MS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin select: first asserted req scanning upward
// from rr_ptr+1 (mod NREQ), so the last owner has the lowest priority.
module rr_arbiter_comb #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  sel,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   // NOTE: every output and temporary gets a default at the top of the
   // block, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      sel      = '0;
      idx      = '0;
      any      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand     = (int'(rr_ptr) + i) % NREQ;
         cand_idx = IDX_W'(cand);
         if (!any && req[cand_idx]) begin
            any           = 1'b1;
            sel[cand_idx] = 1'b1;
            idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/shared_tick_timer.sv
// One prescaler and tick down-counter shared round-robin among NREQ
// requesters; the owner gets a one-cycle done pulse when its delay expires.
module shared_tick_timer
   import shared_tick_timer_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV,
   parameter int NREQ    = 4,
   parameter int CNT_W   = 8,
   parameter int PRE_W   = 23
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] dur,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic                  tick
);

   localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("shared_tick_timer: CLK_DIV must be at least 2");
   end
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("shared_tick_timer: NREQ must be in 2..8");
   end
   if (((CLK_DIV - 1) >> PRE_W) != 0) begin : g_bad_pre_w
      $error("shared_tick_timer: PRE_W too narrow for CLK_DIV");
   end

   state_t           state, state_nxt;
   logic [PRE_W-1:0] pre, pre_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [NREQ-1:0]  grant_nxt, done_nxt;
   logic             busy_nxt, tick_nxt;

   logic [NREQ-1:0]  arb_sel;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_any;
   logic [CNT_W-1:0] dur_sel;

   rr_arbiter_comb #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .sel    (arb_sel),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   assign dur_sel = dur[int'(arb_idx)*CNT_W +: CNT_W];

   always_comb begin
      state_nxt = state;
      pre_nxt   = pre;
      count_nxt = count;
      rr_nxt    = rr_ptr;
      owner_nxt = owner;
      grant_nxt = grant;
      done_nxt  = '0;
      tick_nxt  = 1'b0;

      unique case (state)
         ST_IDLE: begin
            grant_nxt = '0;
            if (arb_any) begin
               grant_nxt = arb_sel;
               owner_nxt = arb_idx;
               count_nxt = dur_sel;
               pre_nxt   = '0;
               state_nxt = (dur_sel != '0) ? ST_RUN : ST_DONE;
            end
         end

         ST_RUN: begin
            // An abort wins over a coincident tick: the owner has walked away.
            if (!req[owner]) begin
               grant_nxt = '0;
               rr_nxt    = owner;
               state_nxt = ST_IDLE;
            end else if (pre == PRE_LAST) begin
               pre_nxt   = '0;
               tick_nxt  = 1'b1;
               count_nxt = count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state_nxt = ST_DONE;
               end
            end else begin
               pre_nxt = pre + PRE_W'(1);
            end
         end

         ST_DONE: begin
            done_nxt  = grant;
            grant_nxt = '0;
            rr_nxt    = owner;
            state_nxt = ST_IDLE;
         end

         default: begin
            grant_nxt = '0;
            state_nxt = ST_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != ST_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         pre    <= '0;
         count  <= '0;
         rr_ptr <= IDX_W'(NREQ - 1);
         owner  <= '0;
         grant  <= '0;
         done   <= '0;
         busy   <= 1'b0;
         tick   <= 1'b0;
      end else begin
         state  <= state_nxt;
         pre    <= pre_nxt;
         count  <= count_nxt;
         rr_ptr <= rr_nxt;
         owner  <= owner_nxt;
         grant  <= grant_nxt;
         done   <= done_nxt;
         busy   <= busy_nxt;
         tick   <= tick_nxt;
      end
   end

endmodule

// File: tb/tb_shared_tick_timer.sv
// Directed bench for shared_tick_timer with CLK_DIV=4, NREQ=4; expected
// values are hand-derived from the cycle-level behaviour of the timer.
module tb_shared_tick_timer;

   localparam int NREQ    = 4;
   localparam int CNT_W   = 8;
   localparam int CLK_DIV = 4;
   localparam int PRE_W   = 3;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*CNT_W-1:0] dur = '0;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic                  tick;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   shared_tick_timer #(
      .CLK_DIV (CLK_DIV),
      .NREQ    (NREQ),
      .CNT_W   (CNT_W),
      .PRE_W   (PRE_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .dur   (dur),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .tick  (tick)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dur(input int i, input int d);
      dur[i*CNT_W +: CNT_W] = CNT_W'(d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Called at the sample just after the grant edge; walks to the done pulse.
   task automatic check_run(input int owner, input int d);
      logic [NREQ-1:0] oh;
      logic [31:0]     exp_tick, exp_done;
      int              last;
      oh       = '0;
      oh[owner] = 1'b1;
      last     = d * CLK_DIV + 1;
      for (int k = 1; k <= last; k++) begin
         step();
         exp_tick = ((k % CLK_DIV) == 0 && k < last) ? 32'd1 : 32'd0;
         exp_done = (k == last) ? 32'(oh) : 32'd0;
         check($sformatf("tick_o%0d_k%0d", owner, k), 32'(tick), exp_tick);
         check($sformatf("done_o%0d_k%0d", owner, k), 32'(done), exp_done);
         if (k == last - 1) check($sformatf("busy_last_tick_o%0d", owner), 32'(busy), 32'd1);
         if (k == last) check($sformatf("grant_at_done_o%0d", owner), 32'(grant), 32'd0);
      end
   endtask

   initial begin
      int order [4];
      int n;
      order = '{0, 1, 3, 0};

      // Reset held with all requests up: every output stays quiet.
      rst = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_dur(i, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("rst_outputs_%0d", i), 32'({grant, done, busy, tick}), 32'd0);
      end
      rst = 1'b0;
      step();
      check("rst_first_grant", 32'(grant), 32'b0001);
      do_reset();

      // Single request, 3 ticks.
      set_dur(2, 3);
      req = 4'b0100;
      step();
      check("single_grant", 32'(grant), 32'b0100);
      check("single_busy", 32'(busy), 32'd1);
      check_run(2, 3);
      req = '0;
      step();
      check("single_idle_outs", 32'({grant, done, busy, tick}), 32'd0);

      // Zero duration: done the cycle after grant, no tick.
      set_dur(1, 0);
      req = 4'b0010;
      step();
      check("zero_grant", 32'(grant), 32'b0010);
      check("zero_tick_a", 32'(tick), 32'd0);
      step();
      check("zero_done", 32'(done), 32'b0010);
      check("zero_grant_clr", 32'(grant), 32'd0);
      check("zero_tick_b", 32'(tick), 32'd0);
      req = '0;
      step();
      check("zero_idle_outs", 32'({grant, done, busy, tick}), 32'd0);

      // Round robin with 0, 1, 3 requesting continuously.
      do_reset();
      for (int i = 0; i < NREQ; i++) set_dur(i, 1);
      req = 4'b1011;
      for (int r = 0; r < 4; r++) begin
         n = 0;
         while (grant == '0 && n < 20) begin step(); n++; end
         check($sformatf("rr_grant_%0d", r), 32'(grant), 32'(1 << order[r]));
         n = 0;
         while (done == '0 && n < 20) begin step(); n++; end
         check($sformatf("rr_done_%0d", r), 32'(done), 32'(1 << order[r]));
         check($sformatf("rr_latency_%0d", r), 32'(n), 32'(CLK_DIV + 1));
         if (r == 3) req = '0;
         else req[order[r]] = 1'b0;
         step();
         if (r < 3) req[order[r]] = 1'b1;
      end
      step();
      check("rr_idle_outs", 32'({grant, done, busy, tick}), 32'd0);

      // Abort: requester 0 drops in the cycle whose closing edge would tick.
      do_reset();
      set_dur(0, 5);
      set_dur(3, 1);
      req = 4'b0001;
      step();
      check("abort_grant0", 32'(grant), 32'b0001);
      req[3] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 4) check("abort_first_tick", 32'(tick), 32'd1);
      end
      req[0] = 1'b0;
      step();
      check("abort_grant_clr", 32'(grant), 32'd0);
      check("abort_no_tick", 32'(tick), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_not_busy", 32'(busy), 32'd0);
      step();
      check("abort_pending_grant3", 32'(grant), 32'b1000);
      check_run(3, 1);
      req = '0;
      step();

      // Reset in the middle of a run: silent abort, then a full restart.
      do_reset();
      set_dur(2, 3);
      req = 4'b0100;
      step();
      check("midrst_grant", 32'(grant), 32'b0100);
      for (int k = 1; k <= 7; k++) step();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("midrst_outputs_%0d", i), 32'({grant, done, busy, tick}), 32'd0);
      end
      rst = 1'b0;
      step();
      check("midrst_regrant", 32'(grant), 32'b0100);
      check_run(2, 3);
      req = '0;
      step();
      check("midrst_idle_outs", 32'({grant, done, busy, tick}), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
